// File: rtl/complex_product_accumulator.sv
// Accumulates LENGTH complex products into one complex dot-product result.
// Define CPA_LAST_EN to add the InLast port for early frame termination.
module complex_product_accumulator #(
    parameter int LENGTH = 16,
    parameter int CNT_W  = 4,
    parameter int ACC_W  = 21
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    InValid,
    output logic                    InReady,
    input  logic [33:0]             InProduct,
`ifdef CPA_LAST_EN
    input  logic                    InLast,
`endif
    output logic                    OutValid,
    input  logic                    OutReady,
    output logic signed [ACC_W-1:0] OutReal,
    output logic signed [ACC_W-1:0] OutImag
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LENGTH - 1);

    logic signed [ACC_W-1:0] acc_real_q, acc_real_d;
    logic signed [ACC_W-1:0] acc_imag_q, acc_imag_d;
    logic        [CNT_W-1:0] count_q, count_d;
    logic                    out_valid_q, out_valid_d;
    logic signed [ACC_W-1:0] out_real_q, out_real_d;
    logic signed [ACC_W-1:0] out_imag_q, out_imag_d;

    logic                    close_beat;
    logic                    accept;
    logic signed [ACC_W-1:0] prod_real, prod_imag;
    logic signed [ACC_W-1:0] sum_real, sum_imag;

    assign prod_real = {{(ACC_W-17){InProduct[33]}}, InProduct[33:17]};
    assign prod_imag = {{(ACC_W-17){InProduct[16]}}, InProduct[16:0]};

`ifdef CPA_LAST_EN
    assign close_beat = (count_q == LAST_CNT) || InLast;
`else
    assign close_beat = (count_q == LAST_CNT);
`endif

    // Only the closing beat can be blocked by an undrained result.
    assign InReady = !(out_valid_q && !OutReady && close_beat);
    assign accept  = InValid && InReady;

    // Term 0 loads rather than adds, so Acc never needs clearing at frame close.
    assign sum_real = (count_q == '0) ? prod_real : acc_real_q + prod_real;
    assign sum_imag = (count_q == '0) ? prod_imag : acc_imag_q + prod_imag;

    always_comb begin
        acc_real_d  = acc_real_q;
        acc_imag_d  = acc_imag_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        out_real_d  = out_real_q;
        out_imag_d  = out_imag_q;

        if (out_valid_q && OutReady) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            if (close_beat) begin
                out_real_d  = sum_real;
                out_imag_d  = sum_imag;
                out_valid_d = 1'b1;
                count_d     = '0;
            end else begin
                acc_real_d = sum_real;
                acc_imag_d = sum_imag;
                count_d    = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            acc_real_q  <= '0;
            acc_imag_q  <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_real_q  <= '0;
            out_imag_q  <= '0;
        end else begin
            acc_real_q  <= acc_real_d;
            acc_imag_q  <= acc_imag_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_real_q  <= out_real_d;
            out_imag_q  <= out_imag_d;
        end
    end

    assign OutValid = out_valid_q;
    assign OutReal  = out_real_q;
    assign OutImag  = out_imag_q;

endmodule

// File: tb/tb_complex_product_accumulator.sv
// Scoreboard bench for complex_product_accumulator: driver predicts frame sums
// from a list of accepted products; an independent monitor checks drained results.
module tb_complex_product_accumulator;

    localparam int LENGTH = 16;
    localparam int CNT_W  = 4;
    localparam int ACC_W  = 21;

    logic              Clk = 1'b0;
    logic              Reset = 1'b0;
    logic              InValid = 1'b0;
    logic              InReady;
    logic [33:0]       InProduct = '0;
    logic              InLast = 1'b0;
    logic              OutValid;
    logic              OutReady = 1'b0;
    logic [ACC_W-1:0]  OutReal;
    logic [ACC_W-1:0]  OutImag;

    complex_product_accumulator #(.LENGTH(LENGTH), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .InValid   (InValid),
        .InReady   (InReady),
        .InProduct (InProduct),
`ifdef CPA_LAST_EN
        .InLast    (InLast),
`endif
        .OutValid  (OutValid),
        .OutReady  (OutReady),
        .OutReal   (OutReal),
        .OutImag   (OutImag)
    );

    always #5 Clk = ~Clk;

    int     n_cmp = 0;
    int     n_bad = 0;
    longint sb_re[$];
    longint sb_im[$];
    int     fr_re[$];
    int     fr_im[$];

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint sx(input logic [ACC_W-1:0] v);
        return longint'($signed(v));
    endfunction

    // One cycle of stimulus; the model decides acceptance from its own state.
    task automatic beat(input bit v, input int re, input int im, input bit rdy,
                        input bit last, output bit accepted);
        bit     closing;
        bit     exp_ready;
        longint s_re, s_im;
        logic [16:0] r17, i17;
        @(negedge Clk);
        r17 = re[16:0];
        i17 = im[16:0];
        InValid   = v;
        InProduct = {r17, i17};
        OutReady  = rdy;
        InLast    = last;
        #2;
`ifdef CPA_LAST_EN
        closing = (fr_re.size() == LENGTH - 1) || last;
`else
        closing = (fr_re.size() == LENGTH - 1);
`endif
        exp_ready = !((sb_re.size() > 0) && !rdy && closing);
        chk("in_ready", longint'(InReady), longint'(exp_ready));
        chk("out_valid", longint'(OutValid), longint'(sb_re.size() > 0));
        accepted = v && exp_ready;
        if (accepted) begin
            fr_re.push_back(re);
            fr_im.push_back(im);
            if (closing) begin
                s_re = 0;
                s_im = 0;
                foreach (fr_re[i]) begin
                    s_re += fr_re[i];
                    s_im += fr_im[i];
                end
                sb_re.push_back(s_re);
                sb_im.push_back(s_im);
                fr_re.delete();
                fr_im.delete();
            end
        end
    endtask

    task automatic send(input int re, input int im, input bit rdy, input bit last);
        bit acc;
        int tries = 0;
        acc = 1'b0;
        while (!acc && tries < 50) begin
            beat(1'b1, re, im, rdy, last, acc);
            tries++;
        end
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    task automatic idle(input int n, input bit rdy);
        bit acc;
        for (int i = 0; i < n; i++) beat(1'b0, 0, 0, rdy, 1'b0, acc);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        InValid = 1'b0;
        InLast  = 1'b0;
        Reset   = 1'b1;
        #1;
        chk("rst_out_valid", longint'(OutValid), 0);
        chk("rst_out_real", sx(OutReal), 0);
        chk("rst_out_imag", sx(OutImag), 0);
        sb_re.delete();
        sb_im.delete();
        fr_re.delete();
        fr_im.delete();
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    // Monitor: whenever a result is presented it must match the oldest prediction.
    initial begin
        forever begin
            @(negedge Clk);
            #4;
            if (!Reset && OutValid) begin
                if (sb_re.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    chk("out_real", sx(OutReal), sb_re[0]);
                    chk("out_imag", sx(OutImag), sb_im[0]);
                    if (OutReady) begin
                        void'(sb_re.pop_front());
                        void'(sb_im.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        bit acc;
        int r, m;
        Reset = 1'b1;
        #12;
        chk("init_out_valid", longint'(OutValid), 0);
        chk("init_out_real", sx(OutReal), 0);
        Reset = 1'b0;
        do_reset();

        for (int i = 0; i < 16; i++) send(100, -50, 1'b1, 1'b0);
        idle(3, 1'b1);

        for (int i = 0; i < 16; i++) send(65535, -65536, 1'b1, 1'b0);
        idle(3, 1'b1);

        for (int i = 0; i < 16; i++) send(1, 1, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) send(2, 0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) beat(1'b1, 2, 0, 1'b0, 1'b0, acc);
        send(2, 0, 1'b1, 1'b0);
        idle(3, 1'b1);

        for (int i = 0; i < 16; i++) begin
            send((i % 2 == 0) ? 3 : -1, 0, 1'b1, 1'b0);
            beat(1'b0, 0, 0, 1'b1, 1'b0, acc);
        end
        idle(2, 1'b1);

        for (int i = 0; i < 7; i++) send(9, -9, 1'b1, 1'b0);
        do_reset();
        for (int i = 0; i < 16; i++) send(11, 4, 1'b0, 1'b0);
        idle(2, 1'b0);
        do_reset();
        for (int i = 0; i < 16; i++) send(5, 5, 1'b1, 1'b0);
        idle(3, 1'b1);

`ifdef CPA_LAST_EN
        for (int i = 0; i < 3; i++) send(10, -10, 1'b1, (i == 2));
        idle(2, 1'b1);
        send(7, 0, 1'b1, 1'b1);
        idle(2, 1'b1);
        for (int i = 0; i < 16; i++) send(1, 2, 1'b1, (i == 15));
        idle(2, 1'b1);
`endif

        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 131071)) - 65536;
            m = int'($urandom_range(0, 131071)) - 65536;
            beat($urandom_range(0, 3) != 0, r, m, $urandom_range(0, 2) != 0,
`ifdef CPA_LAST_EN
                 $urandom_range(0, 9) == 0,
`else
                 1'b0,
`endif
                 acc);
        end
        idle(4, 1'b1);
        chk("scoreboard_empty", longint'(sb_re.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
